// File: rtl/ibex_pkg.sv
// Shared types for the register-file write-port arbiter slice.
package ibex_pkg;

  localparam int unsigned RfAddrWidth = 5;
  localparam int unsigned RfDataWidth = 32;

  typedef logic [RfAddrWidth-1:0] rf_addr_t;

  typedef struct packed {
    logic                   we;
    rf_addr_t               addr;
    logic [RfDataWidth-1:0] data;
  } rf_wreq_t;

endpackage

// File: rtl/ibex_rf_scoreboard.sv
// Pending-destination scoreboard for long-latency writes, with RAW/WAW lookups for the ID stage.
module ibex_rf_scoreboard
  import ibex_pkg::*;
#(
  parameter bit RV32E = 1'b0
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     set_i,
  input  rf_addr_t set_addr_i,
  input  logic     clr_i,
  input  rf_addr_t clr_addr_i,
  input  logic     flush_i,
  input  rf_addr_t raddr_a_i,
  input  rf_addr_t raddr_b_i,
  input  rf_addr_t raddr_rd_i,
  output logic     hazard_a_o,
  output logic     hazard_b_o,
  output logic     hazard_rd_o,
  output logic     err_o
);

  localparam int unsigned IdxW     = RV32E ? 4 : 5;
  localparam int unsigned NumWords = 1 << IdxW;

  logic [NumWords-1:0] sb_q, sb_d;
  logic [IdxW-1:0]     set_idx, clr_idx, a_idx, b_idx, rd_idx;

  assign set_idx = set_addr_i[IdxW-1:0];
  assign clr_idx = clr_addr_i[IdxW-1:0];
  assign a_idx   = raddr_a_i[IdxW-1:0];
  assign b_idx   = raddr_b_i[IdxW-1:0];
  assign rd_idx  = raddr_rd_i[IdxW-1:0];

  // Set is applied after clear so that a same-address collision leaves the bit set.
  always_comb begin
    sb_d = sb_q;
    if (clr_i) begin
      sb_d[clr_idx] = 1'b0;
    end
    if (set_i) begin
      sb_d[set_idx] = 1'b1;
    end
    sb_d[0] = 1'b0;
    if (flush_i) begin
      sb_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  assign hazard_a_o  = sb_q[a_idx];
  assign hazard_b_o  = sb_q[b_idx];
  assign hazard_rd_o = sb_q[rd_idx];
  assign err_o       = set_i & (set_idx != '0) & sb_q[set_idx];

endmodule

// File: rtl/ibex_rf_wport_arbiter.sv
// Shares the RF write port between writeback (primary) and a long-latency unit (secondary),
// holding one deferred secondary write and tracking pending destinations.
module ibex_rf_wport_arbiter
  import ibex_pkg::*;
#(
  parameter bit          RV32E       = 1'b0,
  parameter int unsigned DataWidth   = RfDataWidth,
  parameter int unsigned StarveLimit = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 pri_we_i,
  input  rf_addr_t             pri_waddr_i,
  input  logic [DataWidth-1:0] pri_wdata_i,
  input  logic                 sec_valid_i,
  output logic                 sec_ready_o,
  input  rf_addr_t             sec_waddr_i,
  input  logic [DataWidth-1:0] sec_wdata_i,
  input  logic                 sb_set_i,
  input  rf_addr_t             sb_set_addr_i,
  input  logic                 flush_i,
  input  rf_addr_t             raddr_a_i,
  input  rf_addr_t             raddr_b_i,
  input  rf_addr_t             raddr_rd_i,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic                 hazard_rd_o,
  output logic                 rf_we_o,
  output rf_addr_t             rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 starve_o,
  output logic                 err_o
);

  localparam int unsigned     CntW   = $clog2(StarveLimit + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(StarveLimit);

  rf_wreq_t        buf_q, buf_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sec_hs, sec_nz, waw_kill;
  logic            clr;
  rf_addr_t        clr_addr;

  // Ready depends only on state, except that a flush cycle refuses new work.
  assign sec_ready_o = ~buf_q.we & ~flush_i;
  assign sec_hs      = sec_valid_i & sec_ready_o;
  assign sec_nz      = (sec_waddr_i != '0);
  assign waw_kill    = pri_we_i & buf_q.we & (pri_waddr_i == buf_q.addr);

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = pri_waddr_i;
    rf_wdata_o = pri_wdata_i;
    buf_d      = buf_q;
    clr        = 1'b0;
    clr_addr   = buf_q.addr;

    if (pri_we_i) begin
      rf_we_o = 1'b1;
      if (waw_kill) begin
        buf_d.we = 1'b0;
        clr      = 1'b1;
      end
      if (sec_hs && sec_nz) begin
        buf_d.we   = 1'b1;
        buf_d.addr = sec_waddr_i;
        buf_d.data = sec_wdata_i;
      end
    end else if (buf_q.we && !flush_i) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = buf_q.addr;
      rf_wdata_o = buf_q.data;
      buf_d.we   = 1'b0;
      clr        = 1'b1;
    end else if (sec_hs && sec_nz) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = sec_waddr_i;
      rf_wdata_o = sec_wdata_i;
      clr        = 1'b1;
      clr_addr   = sec_waddr_i;
    end

    if (flush_i) begin
      buf_d.we = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!buf_d.we) begin
      cnt_d = '0;
    end else if (buf_q.we && pri_we_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign starve_o = (cnt_q == CntMax);

  ibex_rf_scoreboard #(
    .RV32E (RV32E)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .set_i       (sb_set_i),
    .set_addr_i  (sb_set_addr_i),
    .clr_i       (clr),
    .clr_addr_i  (clr_addr),
    .flush_i     (flush_i),
    .raddr_a_i   (raddr_a_i),
    .raddr_b_i   (raddr_b_i),
    .raddr_rd_i  (raddr_rd_i),
    .hazard_a_o  (hazard_a_o),
    .hazard_b_o  (hazard_b_o),
    .hazard_rd_o (hazard_rd_o),
    .err_o       (err_o)
  );

endmodule
